// File: rtl/tanh_share_arbiter.sv
// Round-robin time-shared Q4.12 piecewise-linear tanh unit.
// One operation in flight: IDLE (grant/capture) -> EVAL (compute) -> RESP (hold until accepted).

// Combinational Q4.12 tanh approximation, symmetric about zero.
module tanh_share_arbiter_pwl (
  input  logic [15:0] op,
  output logic [15:0] res
);
  logic        sgn;
  logic [15:0] mag;
  logic [15:0] y;

  // Magnitude, three-segment fit on the magnitude, then restore sign.
  // 0x8000 negates to itself and lands in the saturation segment.
  always_comb begin
    sgn = op[15];
    mag = sgn ? (16'd0 - op) : op;
    if (mag < 16'h0800)      y = mag;
    else if (mag < 16'h1333) y = (mag >> 1) + 16'h0400;
    else if (mag < 16'h2666) y = (mag >> 3) + 16'h0B33;
    else                     y = 16'h1000;
    res = sgn ? (16'd0 - y) : y;
  end
endmodule

module tanh_share_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int CNT_W   = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0][15:0]      req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [15:0]                   rsp_data,
  input  logic [NUM_REQ-1:0]            rsp_ready,
  output logic                          busy,
  output logic [CNT_W-1:0]              done_count
);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, EVAL = 2'd1, RESP = 2'd2} state_t;

  state_t          state;
  logic [IW-1:0]   last_grant;
  logic [IW-1:0]   id_q;
  logic [15:0]     op_q;
  logic [15:0]     res_q;
  logic [15:0]     tanh_y;
  logic [IW-1:0]   scan_idx;
  logic [IW-1:0]   gnt_idx;
  logic            gnt_found;

  tanh_share_arbiter_pwl u_pwl (.op(op_q), .res(tanh_y));

  // Rotating priority search: first valid requester after last_grant, wrapping.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    scan_idx  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      scan_idx = IW'((int'(last_grant) + k) % NUM_REQ);
      if (!gnt_found && req_valid[scan_idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = scan_idx;
      end
    end
  end

  // Grant is only offered while idle and out of reset.
  assign req_ready = (state == IDLE && !reset && gnt_found)
                     ? (NUM_REQ'(1) << gnt_idx) : '0;
  assign busy      = (state != IDLE) && !reset;
  assign rsp_data  = res_q;

  // Single FSM: capture operand, evaluate, hold response until its owner accepts.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= IW'(NUM_REQ - 1);
      op_q       <= '0;
      id_q       <= '0;
      res_q      <= '0;
      rsp_valid  <= '0;
      done_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (gnt_found) begin
            op_q  <= req_data[gnt_idx];
            id_q  <= gnt_idx;
            state <= EVAL;
          end
        end
        EVAL: begin
          res_q     <= tanh_y;
          rsp_valid <= NUM_REQ'(1) << id_q;
          state     <= RESP;
        end
        RESP: begin
          // Only the owner's rsp_ready matters; others are ignored.
          if (rsp_ready[id_q]) begin
            last_grant <= id_q;
            done_count <= done_count + CNT_W'(1);
            rsp_valid  <= '0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_tanh_share_arbiter.sv
// Bench for tanh_share_arbiter: table-driven operands, scoreboard-checked responses,
// plus hand sequences for fairness, backpressure, reset mid-operation and counter wrap.
module tb_tanh_share_arbiter;
  localparam int NR = 4;
  localparam int CW = 4;

  typedef struct { logic [15:0] op; logic [15:0] exp; } vec_t;
  typedef struct { int id; logic [15:0] exp; } sb_t;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [NR-1:0]        req_valid;
  logic [NR-1:0][15:0]  req_data;
  logic [NR-1:0]        req_ready;
  logic [NR-1:0]        rsp_valid;
  logic [15:0]          rsp_data;
  logic [NR-1:0]        rsp_ready;
  logic                 busy;
  logic [CW-1:0]        done_count;

  tanh_share_arbiter #(.NUM_REQ(NR), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .rsp_ready(rsp_ready), .busy(busy), .done_count(done_count)
  );

  always #5 clk = ~clk;

  int          nvec = 0;
  int          nerr = 0;
  sb_t         sb[$];
  int          grant_log[$];
  logic [15:0] exp_of [NR];
  int          ph = 0;
  int          model_last = NR - 1;
  logic [CW-1:0] model_cnt = '0;
  logic [15:0] last_rsp;
  int          last_id;
  vec_t        tv [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    nvec++;
    if (act !== req) begin
      nerr++;
      $display("FAIL %s: got %h want %h at %0t", name, act, req, $time);
    end
  endtask

  task automatic timeout(input string name);
    nvec++;
    nerr++;
    $display("FAIL %s: timed out at %0t", name, $time);
  endtask

  // Reference model of the handshake, sampled on the falling edge.
  int          mg;
  logic [NR-1:0] mer;
  always @(negedge clk) begin
    if (reset) begin
      chk("rst_ctrl", {27'd0, busy, req_ready}, 32'd0);
      sb.delete();
      ph         = 0;
      model_last = NR - 1;
      model_cnt  = '0;
    end else begin
      case (ph)
        0: begin
          mg  = -1;
          mer = '0;
          for (int k = 1; k <= NR; k++)
            if (mg < 0 && req_valid[(model_last + k) % NR]) mg = (model_last + k) % NR;
          if (mg >= 0) mer[mg] = 1'b1;
          chk("ctrl_idle", {27'd0, busy, req_ready}, {27'd0, 1'b0, mer});
          chk("rsp_idle", 32'(rsp_valid), 32'd0);
          if (mg >= 0) begin
            sb.push_back('{id: mg, exp: exp_of[mg]});
            grant_log.push_back(mg);
            ph = 1;
          end
        end
        1: begin
          chk("ctrl_eval", {27'd0, busy, req_ready}, {27'd0, 1'b1, 4'b0000});
          chk("rsp_eval", 32'(rsp_valid), 32'd0);
          ph = 2;
        end
        default: begin
          mer = '0;
          mer[sb[0].id] = 1'b1;
          chk("ctrl_resp", {27'd0, busy, req_ready}, {27'd0, 1'b1, 4'b0000});
          chk("rsp_valid", 32'(rsp_valid), 32'(mer));
          chk("rsp_data", 32'(rsp_data), 32'(sb[0].exp));
          if (rsp_ready[sb[0].id]) begin
            chk("done_cnt", 32'(done_count), 32'(model_cnt));
            model_cnt  = model_cnt + 1'b1;
            model_last = sb[0].id;
            last_rsp   = rsp_data;
            last_id    = sb[0].id;
            void'(sb.pop_front());
            ph = 0;
          end
        end
      endcase
    end
  end

  task automatic do_reset();
    @(posedge clk); #1 reset = 1'b1;
    req_valid = '0;
    @(posedge clk); #1 reset = 1'b0;
  endtask

  task automatic wait_grant(input int i);
    bit ok = 0;
    for (int c = 0; c < 20 && !ok; c++) begin
      @(negedge clk);
      if (req_ready[i]) ok = 1;
    end
    if (!ok) timeout("grant_wait");
    @(posedge clk); #1 req_valid[i] = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int c = 0; c < 40 && !ok; c++) begin
      @(posedge clk);
      if (ph == 0 && sb.size() == 0) ok = 1;
    end
    if (!ok) timeout("idle_wait");
  endtask

  task automatic run_one(input int i, input logic [15:0] op, input logic [15:0] ex);
    @(posedge clk); #1;
    req_data[i]  = op;
    exp_of[i]    = ex;
    req_valid[i] = 1'b1;
    wait_grant(i);
    wait_idle();
  endtask

  initial begin
    int exp_order [5];
    bit ok;
    tv[0] = '{16'h1000, 16'h0C00};
    tv[1] = '{16'h0400, 16'h0400};
    tv[2] = '{16'hF000, 16'hF400};
    tv[3] = '{16'h2000, 16'h0F33};
    tv[4] = '{16'h3000, 16'h1000};
    tv[5] = '{16'h8000, 16'hF000};
    tv[6] = '{16'h07FF, 16'h07FF};
    tv[7] = '{16'h0800, 16'h0800};
    tv[8] = '{16'h1333, 16'h0D99};
    tv[9] = '{16'h2665, 16'h0FFF};
    exp_order = '{0, 1, 2, 3, 0};
    for (int i = 0; i < NR; i++) exp_of[i] = '0;

    // Reset state, with every requester asking during reset.
    reset = 1'b1; req_valid = '1; req_data = '0; rsp_ready = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_rspv", 32'(rsp_valid), 32'd0);
    chk("rst_rspd", 32'(rsp_data), 32'd0);
    chk("rst_cnt", 32'(done_count), 32'd0);
    @(posedge clk); #1 req_valid = '0; reset = 1'b0;

    // Single request on requester 0.
    rsp_ready = '1;
    @(posedge clk); #1 req_data[0] = 16'h1000; exp_of[0] = 16'h0C00; req_valid = 4'b0001;
    @(negedge clk);
    chk("t1_ready", 32'(req_ready), 32'h1);
    @(posedge clk); #1 req_valid = '0;
    @(negedge clk);
    @(negedge clk);
    chk("t1_rspv", 32'(rsp_valid), 32'h1);
    chk("t1_rspd", 32'(rsp_data), 32'h0C00);
    @(negedge clk);
    chk("t1_cnt", 32'(done_count), 32'h1);

    // Operand table on requester 2.
    for (int v = 0; v < 10; v++) begin
      run_one(2, tv[v].op, tv[v].exp);
      chk("tbl_data", 32'(last_rsp), 32'(tv[v].exp));
      chk("tbl_id", 32'(last_id), 32'd2);
    end

    // Fairness: all requesters held valid.
    do_reset();
    grant_log.delete();
    @(posedge clk); #1;
    for (int i = 0; i < NR; i++) begin
      req_data[i] = tv[i + 2].op;
      exp_of[i]   = tv[i + 2].exp;
    end
    req_valid = '1;
    ok = 0;
    for (int c = 0; c < 60 && !ok; c++) begin
      @(negedge clk);
      if (grant_log.size() >= 5) ok = 1;
    end
    if (!ok) timeout("fair_wait");
    @(posedge clk); #1 req_valid = '0;
    wait_idle();
    for (int k = 0; k < 5; k++)
      chk("fair_order", (k < grant_log.size()) ? 32'(grant_log[k]) : 32'hFFFF_FFFF,
          32'(exp_order[k]));

    // Backpressure on requester 1 while requester 3 waits.
    rsp_ready = 4'b1101;
    @(posedge clk); #1 req_data[1] = 16'h2000; exp_of[1] = 16'h0F33; req_valid[1] = 1'b1;
    wait_grant(1);
    ok = 0;
    for (int c = 0; c < 10 && !ok; c++) begin
      @(negedge clk);
      if (rsp_valid[1]) ok = 1;
    end
    if (!ok) timeout("bp_rsp_wait");
    @(posedge clk); #1 req_data[3] = 16'hF000; exp_of[3] = 16'hF400; req_valid[3] = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("bp_rspv", 32'(rsp_valid), 32'h2);
      chk("bp_rspd", 32'(rsp_data), 32'h0F33);
      chk("bp_busy_rdy", {27'd0, busy, req_ready}, 32'h10);
      @(posedge clk); #1 rsp_ready = 4'($urandom) & 4'b1101;
    end
    rsp_ready = '1;
    wait_grant(3);
    wait_idle();
    chk("bp_next", 32'(last_id), 32'd3);

    // Reset while an operand is in EVAL.
    @(posedge clk); #1 req_data[2] = 16'h3000; exp_of[2] = 16'h1000; req_valid[2] = 1'b1;
    wait_grant(2);
    reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("rstev_busy", 32'(busy), 32'd0);
    chk("rstev_rspv", 32'(rsp_valid), 32'd0);
    chk("rstev_cnt", 32'(done_count), 32'd0);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      chk("rstev_quiet", 32'(rsp_valid), 32'd0);
    end

    // Counter wrap: 17 completions with a 4-bit counter.
    do_reset();
    for (int n = 0; n < 17; n++) run_one(n % NR, tv[n % 10].op, tv[n % 10].exp);
    @(negedge clk);
    chk("wrap_cnt", 32'(done_count), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/tanh_share_arbiter.md
Name: tanh_share_arbiter

Overview:
- Time-shares one combinational Q4.12 tanh unit (16-bit signed in/out, piecewise-linear) among NUM_REQ independent requesters, such as the per-gate activation stages of the RNN cell.
- Round-robin arbitration, a valid/ready handshake on each request and response port, and a registered operand and result stage.
- Only one operation is in flight at a time.
- Also exports a busy flag and a wrapping count of completed operations for the host status register.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- CNT_W, 16, width of the completed-operation counter

Ports:
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  synchronous active-high reset
- req_valid  input  NUM_REQ  per-requester operand valid
- req_data  input  NUM_REQ*16  packed Q4.12 operands; requester i occupies bits [16*i+15:16*i]
- req_ready  output  NUM_REQ  one-hot grant/accept, combinational
- rsp_valid  output  NUM_REQ  one-hot result valid, registered
- rsp_data  output  16  Q4.12 tanh result, shared by all responders
- rsp_ready  input  NUM_REQ  per-requester result accept
- busy  output  1  high whenever state != IDLE
- done_count  output  CNT_W  completed operations, wraps modulo 2^CNT_W

Behaviour:
- Reset is synchronous and active-high. Reset values:
  - state=IDLE, last_grant=NUM_REQ-1 (requester 0 has first priority after reset)
  - op_q=0, id_q=0, res_q=0, rsp_data=0, rsp_valid=0, done_count=0
  - req_ready=0 and busy=0 while reset is high
- A reset asserted mid-operation discards the in-flight operand and result. No response is issued for it.
- State machine:
  - IDLE:
    - If any req_valid is set, grant g = the first set bit searching upward from (last_grant+1) mod NUM_REQ, with wrap-around.
    - req_ready[g]=1 in the same cycle; all other req_ready bits are 0.
    - On the edge: op_q<=req_data[g], id_q<=g, go to EVAL.
    - If no req_valid is set, stay in IDLE and hold all req_ready at 0.
  - EVAL: res_q <= tanh(op_q); go to RESP. req_ready is all 0.
  - RESP:
    - rsp_valid[id_q]=1, rsp_data=res_q; all req_ready are 0.
    - When rsp_ready[id_q]=1: last_grant<=id_q, done_count<=done_count+1, go to IDLE.
    - Otherwise hold. rsp_valid and rsp_data stay stable until accepted.
    - rsp_ready bits of other requesters are ignored.
- Timing:
  - Latency: operand accepted on edge T, rsp_valid high in the cycle after edge T+1.
  - Minimum issue interval is 3 cycles.
  - A requester may hold req_valid through its own pending response; it is re-arbitrated in IDLE like any other requester.
- tanh arithmetic, Q4.12:
  - sign = in<0; x = magnitude as unsigned 16 bits. For in=0x8000, x=0x8000.
  - x<0x0800: y=x
  - x<0x1333: y=(x>>1)+0x0400
  - x<0x2666: y=(x>>3)+0x0B33
  - otherwise: y=0x1000
  - out = sign ? -y : y
- Simultaneous events:
  - A request arriving in the same cycle as a RESP handshake is not granted until the next IDLE cycle.
  - req_valid dropped before a grant is legal; nothing is captured.
- done_count wraps from 2^CNT_W-1 to 0 with no flag.

Test Plan:
- Reset, then a single request, in0=0x1000: req_ready[0] high the same cycle; rsp_valid=4'b0001 two edges later; rsp_data=0x0C00; done_count=1.
- Sign, breakpoint and saturation operands on requester 2, rsp_ready tied high:
  - 0x0400->0x0400
  - 0xF000->0xF400
  - 0x2000->0x0F33
  - 0x3000->0x1000
  - 0x8000->0xF000
  - 0x07FF->0x07FF, 0x0800->0x0800
- Fairness: all four req_valid held high with distinct operands, rsp_ready high. Grant order is 0,1,2,3,0; each response is routed to the matching rsp_valid bit; no requester is skipped.
- Backpressure: rsp_ready[1] held low for 10 cycles in RESP. rsp_valid[1] and rsp_data stay stable, busy=1, all req_ready=0, and other requesters' rsp_ready are ignored. Release gives the handshake and return to IDLE.
- Reset during EVAL with a pending operand: the next cycle shows state IDLE, rsp_valid=0 and done_count unchanged (0), and no response is ever emitted for that operand.
- Counter wrap with CNT_W=4: 17 completed operations leave done_count=1.
